// File: rtl/frame_timing_gen.sv
// frame_timing_gen: test-video source for the frame control chain.
// Emits frame_start, data_valid and an RGB test pattern at a resolution that
// is latched once per frame, so downstream logic only ever sees whole frames.
// All outputs come from flops whose inputs are decoded from the next state.
module frame_timing_gen #(
  parameter int H_BLANK        = 280,
  parameter int V_BLANK_CYCLES = 4096,
  parameter int FS_WIDTH       = 2
) (
  input  logic        sys_clk_i,
  input  logic        reset_i,
  input  logic        enable_i,
  input  logic [15:0] hres_i,
  input  logic [15:0] vres_i,
  input  logic [1:0]  pattern_sel_i,
  output logic        frame_start_o,
  output logic        data_valid_o,
  output logic [7:0]  data_r_o,
  output logic [7:0]  data_g_o,
  output logic [7:0]  data_b_o,
  output logic [15:0] hres_o,
  output logic [15:0] vres_o,
  output logic [15:0] frame_cnt_o,
  output logic        busy_o
);

  typedef enum logic [2:0] {S_IDLE, S_FS, S_HBLANK, S_ACTIVE, S_VBLANK} state_t;

  localparam logic [15:0] FS_LAST = 16'(FS_WIDTH - 1);
  localparam logic [15:0] HB_LAST = 16'(H_BLANK - 1);
  localparam logic [15:0] VB_LAST = 16'(V_BLANK_CYCLES - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;          // cycles spent in FS / HBLANK / VBLANK
  logic [15:0] h_cnt_q, h_cnt_d;
  logic [15:0] v_cnt_q, v_cnt_d;
  logic [2:0]  bar_idx_q, bar_idx_d;  // colour-bar index, saturates at 7 (black)
  logic [15:0] bar_pix_q, bar_pix_d;  // pixel position inside the current bar
  logic [15:0] bar_w_q, bar_w_d;
  logic [1:0]  pat_q, pat_d;
  logic [15:0] hres_q, hres_d;
  logic [15:0] vres_q, vres_d;
  logic [15:0] fcnt_q, fcnt_d;
  logic        fs_q, fs_d;
  logic        dv_q, dv_d;
  logic [7:0]  r_q, r_d, g_q, g_d, b_q, b_d;
  logic        busy_q, busy_d;
  logic        latch;

  // Next state, per-frame latching and the pixel colour for the next cycle
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    h_cnt_d   = h_cnt_q;
    v_cnt_d   = v_cnt_q;
    bar_idx_d = bar_idx_q;
    bar_pix_d = bar_pix_q;
    bar_w_d   = bar_w_q;
    pat_d     = pat_q;
    hres_d    = hres_q;
    vres_d    = vres_q;
    fcnt_d    = fcnt_q;
    latch     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (enable_i) latch = 1'b1;
      end
      S_FS: begin
        if (cnt_q == FS_LAST) begin
          state_d = S_HBLANK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_HBLANK: begin
        if (cnt_q == HB_LAST) begin
          state_d   = S_ACTIVE;
          h_cnt_d   = '0;
          bar_idx_d = '0;
          bar_pix_d = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_ACTIVE: begin
        if (h_cnt_q == hres_q - 16'd1) begin
          v_cnt_d = v_cnt_q + 16'd1;
          cnt_d   = '0;
          state_d = (v_cnt_q == vres_q - 16'd1) ? S_VBLANK : S_HBLANK;
        end else begin
          h_cnt_d = h_cnt_q + 16'd1;
          if (bar_pix_q == bar_w_q - 16'd1) begin
            bar_pix_d = '0;
            bar_idx_d = (bar_idx_q == 3'd7) ? 3'd7 : bar_idx_q + 3'd1;
          end else begin
            bar_pix_d = bar_pix_q + 16'd1;
          end
        end
      end
      S_VBLANK: begin
        if (cnt_q == VB_LAST) begin
          if (enable_i) latch = 1'b1;
          else          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A zero in either dimension keeps the previous resolution intact
    if (latch) begin
      state_d = S_FS;
      cnt_d   = '0;
      h_cnt_d = '0;
      v_cnt_d = '0;
      if (hres_i != 16'd0 && vres_i != 16'd0) begin
        hres_d = hres_i;
        vres_d = vres_i;
      end
      bar_w_d = hres_d >> 3;
      pat_d   = pattern_sel_i;
      fcnt_d  = fcnt_q + 16'd1;
    end

    fs_d   = (state_d == S_FS);
    busy_d = (state_d != S_IDLE);
    dv_d   = (state_d == S_ACTIVE);
    r_d    = 8'h00;
    g_d    = 8'h00;
    b_d    = 8'h00;
    if (dv_d) begin
      case (pat_d)
        2'd0: if (bar_w_d != 16'd0) begin
          r_d = {8{~bar_idx_d[1]}};
          g_d = {8{~bar_idx_d[2]}};
          b_d = {8{~bar_idx_d[0]}};
        end
        2'd1: begin
          r_d = h_cnt_d[7:0];
          g_d = h_cnt_d[7:0];
          b_d = h_cnt_d[7:0];
        end
        2'd2: begin
          r_d = 8'hFF;
          g_d = 8'hFF;
          b_d = 8'hFF;
        end
        default: begin
          r_d = {8{~(h_cnt_d[4] ^ v_cnt_d[4])}};
          g_d = {8{~(h_cnt_d[4] ^ v_cnt_d[4])}};
          b_d = {8{~(h_cnt_d[4] ^ v_cnt_d[4])}};
        end
      endcase
    end
  end

  // State, counters and registered outputs; reset returns to IDLE at once
  always_ff @(posedge sys_clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
      bar_idx_q <= '0;
      bar_pix_q <= '0;
      bar_w_q   <= '0;
      pat_q     <= '0;
      hres_q    <= 16'd1280;
      vres_q    <= 16'd720;
      fcnt_q    <= '0;
      fs_q      <= 1'b0;
      dv_q      <= 1'b0;
      r_q       <= '0;
      g_q       <= '0;
      b_q       <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      bar_idx_q <= bar_idx_d;
      bar_pix_q <= bar_pix_d;
      bar_w_q   <= bar_w_d;
      pat_q     <= pat_d;
      hres_q    <= hres_d;
      vres_q    <= vres_d;
      fcnt_q    <= fcnt_d;
      fs_q      <= fs_d;
      dv_q      <= dv_d;
      r_q       <= r_d;
      g_q       <= g_d;
      b_q       <= b_d;
      busy_q    <= busy_d;
    end
  end

  assign frame_start_o = fs_q;
  assign data_valid_o  = dv_q;
  assign data_r_o      = r_q;
  assign data_g_o      = g_q;
  assign data_b_o      = b_q;
  assign hres_o        = hres_q;
  assign vres_o        = vres_q;
  assign frame_cnt_o   = fcnt_q;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_frame_timing_gen.sv
// Directed bench for frame_timing_gen: walks each frame cycle by cycle and
// checks every output against hand-derived timing and a pattern model.
module tb_frame_timing_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic [15:0] hres_i = 16'd0, vres_i = 16'd0;
  logic [1:0]  pat_i = 2'd0;
  logic        fs, dv, busy;
  logic [7:0]  r, g, b;
  logic [15:0] hres_o, vres_o, fcnt;

  int tests = 0;
  int fails = 0;

  frame_timing_gen #(.H_BLANK(4), .V_BLANK_CYCLES(10), .FS_WIDTH(2)) dut (
    .sys_clk_i(clk), .reset_i(rst), .enable_i(en),
    .hres_i(hres_i), .vres_i(vres_i), .pattern_sel_i(pat_i),
    .frame_start_o(fs), .data_valid_o(dv),
    .data_r_o(r), .data_g_o(g), .data_b_o(b),
    .hres_o(hres_o), .vres_o(vres_o), .frame_cnt_o(fcnt), .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected RGB for a pixel, computed arithmetically
  function automatic logic [23:0] px(input int pat, input int h, input int v, input int hres);
    int bw, idx;
    logic [23:0] bars [8];
    bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    case (pat)
      0: begin
        bw = hres / 8;
        if (bw == 0) return 24'h0;
        idx = h / bw;
        if (idx > 7) idx = 7;
        return bars[idx];
      end
      1: return {3{8'(h % 256)}};
      2: return 24'hFFFFFF;
      default: return ((((h / 16) % 2) ^ ((v / 16) % 2)) == 0) ? 24'hFFFFFF : 24'h0;
    endcase
  endfunction

  task automatic wait_fs(input int max);
    for (int i = 0; i < max; i++) begin
      if (fs === 1'b1) break;
      step();
    end
    chk("wait_frame_start", {31'b0, fs}, 1);
  endtask

  // Starts at the first frame_start cycle; ends on the cycle after VBLANK.
  // At pixel 0 of line chg_line the inputs are changed to nh/nv/np/nen.
  task automatic frame(input int h, input int v, input int pat, input int fc,
                       input int chg_line, input int nh, input int nv,
                       input int np, input int nen);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("fs%0d_fs", i), {31'b0, fs}, 1);
      chk($sformatf("fs%0d_dv", i), {31'b0, dv}, 0);
      chk($sformatf("fs%0d_busy", i), {31'b0, busy}, 1);
      if (i == 0) begin
        chk("frame_cnt", {16'b0, fcnt}, fc);
        chk("hres_o", {16'b0, hres_o}, h);
        chk("vres_o", {16'b0, vres_o}, v);
      end
      step();
    end
    for (int l = 0; l < v; l++) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("hb_l%0d_c%0d_fs", l, i), {31'b0, fs}, 0);
        chk($sformatf("hb_l%0d_c%0d_dv", l, i), {31'b0, dv}, 0);
        chk($sformatf("hb_l%0d_c%0d_rgb", l, i), {8'b0, r, g, b}, 0);
        step();
      end
      for (int p = 0; p < h; p++) begin
        if (l == chg_line && p == 0) begin
          hres_i = 16'(nh);
          vres_i = 16'(nv);
          pat_i  = 2'(np);
          en     = nen[0];
        end
        chk($sformatf("act_l%0d_p%0d_dv", l, p), {31'b0, dv}, 1);
        chk($sformatf("act_l%0d_p%0d_rgb", l, p), {8'b0, r, g, b}, {8'b0, px(pat, p, l, h)});
        step();
      end
    end
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("vb_c%0d_dv", i), {31'b0, dv}, 0);
      chk($sformatf("vb_c%0d_fs", i), {31'b0, fs}, 0);
      chk($sformatf("vb_c%0d_busy", i), {31'b0, busy}, 1);
      if (i == 0) begin
        chk("hres_o_held", {16'b0, hres_o}, h);
        chk("vres_o_held", {16'b0, vres_o}, v);
      end
      step();
    end
  endtask

  task automatic chk_idle(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      chk($sformatf("idle%0d_busy", i), {31'b0, busy}, 0);
      chk($sformatf("idle%0d_fs", i), {31'b0, fs}, 0);
      chk($sformatf("idle%0d_dv", i), {31'b0, dv}, 0);
      step();
    end
  endtask

  initial begin
    #2 rst = 1'b1;
    step();
    step();
    // Reset values
    chk("rst_fs", {31'b0, fs}, 0);
    chk("rst_dv", {31'b0, dv}, 0);
    chk("rst_rgb", {8'b0, r, g, b}, 0);
    chk("rst_hres", {16'b0, hres_o}, 1280);
    chk("rst_vres", {16'b0, vres_o}, 720);
    chk("rst_fcnt", {16'b0, fcnt}, 0);
    chk("rst_busy", {31'b0, busy}, 0);

    // Basic 16x3 colour bars, then zero-resolution request, then mid-frame change
    hres_i = 16'd16; vres_i = 16'd3; pat_i = 2'd0; en = 1'b1;
    rst = 1'b0;
    step();
    chk("fs_after_enable", {31'b0, fs}, 1);
    frame(16, 3, 0, 1, -1, 0, 0, 0, 1);
    frame(16, 3, 0, 2, 0, 0, 3, 0, 1);
    frame(16, 3, 0, 3, 1, 8, 2, 0, 1);
    // Stop request during line 0: frame completes, then IDLE
    frame(8, 2, 0, 4, 0, 8, 2, 0, 0);
    chk_idle(20);

    // Reset during ACTIVE
    hres_i = 16'd16; vres_i = 16'd3; pat_i = 2'd0; en = 1'b1;
    wait_fs(5);
    for (int i = 0; i < 9; i++) step();
    chk("pre_rst_dv", {31'b0, dv}, 1);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_dv", {31'b0, dv}, 0);
    chk("mid_rst_rgb", {8'b0, r, g, b}, 0);
    chk("mid_rst_hres", {16'b0, hres_o}, 1280);
    chk("mid_rst_vres", {16'b0, vres_o}, 720);
    chk("mid_rst_fcnt", {16'b0, fcnt}, 0);
    chk("mid_rst_busy", {31'b0, busy}, 0);
    step();
    rst = 1'b0;
    step();
    chk("fs_after_rst", {31'b0, fs}, 1);
    frame(16, 3, 0, 1, 0, 300, 1, 1, 1);

    // Ramp, checkerboard, narrow bars (all black), solid white
    frame(300, 1, 1, 2, 0, 64, 2, 3, 1);
    frame(64, 2, 3, 3, 0, 5, 1, 0, 1);
    frame(5, 1, 0, 4, 0, 8, 1, 2, 1);
    frame(8, 1, 2, 5, 0, 8, 1, 2, 0);
    chk_idle(5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
